// File: rtl/apb_err_demux.sv
// APB 1-to-N demultiplexer with address decode, decode-error response,
// access-phase watchdog and sticky error capture with an interrupt pulse.
// Forwarding is combinational. Only the transfer-tracking state and the
// error capture registers are clocked.
module apb_err_demux #(
    parameter int NrPorts       = 4,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter logic [NrPorts*AddrWidth-1:0] AddrBase = {
        32'h0003_0300, 32'h0003_0200, 32'h0003_0100, 32'h0003_0000},
    parameter logic [NrPorts*AddrWidth-1:0] AddrLast = {
        32'h0003_0400, 32'h0003_0300, 32'h0003_0200, 32'h0003_0100},
    parameter int TimeoutCycles = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           s_psel_i,
    input  logic                           s_penable_i,
    input  logic                           s_pwrite_i,
    input  logic [AddrWidth-1:0]           s_paddr_i,
    input  logic [DataWidth-1:0]           s_pwdata_i,
    output logic [DataWidth-1:0]           s_prdata_o,
    output logic                           s_pready_o,
    output logic                           s_pslverr_o,
    output logic [NrPorts-1:0]             m_psel_o,
    output logic                           m_penable_o,
    output logic                           m_pwrite_o,
    output logic [AddrWidth-1:0]           m_paddr_o,
    output logic [DataWidth-1:0]           m_pwdata_o,
    input  logic [NrPorts*DataWidth-1:0]   m_prdata_i,
    input  logic [NrPorts-1:0]             m_pready_i,
    input  logic [NrPorts-1:0]             m_pslverr_i,
    output logic                           err_irq_o,
    output logic [1:0]                     err_cause_o,
    output logic [AddrWidth-1:0]           err_addr_o,
    input  logic                           err_clr_i
);

    localparam int SelW = (NrPorts > 1) ? $clog2(NrPorts) : 1;
    localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TimeoutCycles);

    localparam logic [1:0] CauseDecode  = 2'b01;
    localparam logic [1:0] CauseTimeout = 2'b10;

    typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

    state_t              r_state;
    logic [SelW-1:0]     r_sel;
    logic                r_miss;
    logic [CntW-1:0]     r_cnt;
    logic                r_err_irq;
    logic [1:0]          r_err_cause;
    logic [AddrWidth-1:0] r_err_addr;

    logic [SelW-1:0]     w_dec_sel;
    logic                w_dec_miss;
    logic [SelW-1:0]     w_sel;
    logic                w_miss;
    logic                w_port_rdy;
    logic                w_port_err;
    logic [DataWidth-1:0] w_port_rdata;
    logic                w_err;
    logic [1:0]          w_cause;

    // Address decode; scanning downwards lets the lowest matching index win.
    always_comb begin
        w_dec_sel  = '0;
        w_dec_miss = 1'b1;
        for (int i = NrPorts - 1; i >= 0; i--) begin
            if ((s_paddr_i >= AddrBase[i*AddrWidth +: AddrWidth]) &&
                (s_paddr_i <  AddrLast[i*AddrWidth +: AddrWidth])) begin
                w_dec_sel  = SelW'(i);
                w_dec_miss = 1'b0;
            end
        end
    end

    // Live decode while idle, latched decode for the rest of the transfer.
    assign w_sel  = (r_state == ST_ACCESS) ? r_sel  : w_dec_sel;
    assign w_miss = (r_state == ST_ACCESS) ? r_miss : w_dec_miss;

    // One-hot select; held low while reset is asserted so a dropped transfer stops at once.
    always_comb begin
        m_psel_o = '0;
        for (int i = 0; i < NrPorts; i++) begin
            m_psel_o[i] = s_psel_i & ~w_miss & ~rst_i & (w_sel == SelW'(i));
        end
    end

    assign m_penable_o = s_penable_i;
    assign m_pwrite_o  = s_pwrite_i;
    assign m_paddr_o   = s_paddr_i;
    assign m_pwdata_o  = s_pwdata_i;

    // Response of the port latched for the current transfer.
    always_comb begin
        w_port_rdy   = 1'b0;
        w_port_err   = 1'b0;
        w_port_rdata = '0;
        for (int i = 0; i < NrPorts; i++) begin
            if (r_sel == SelW'(i)) begin
                w_port_rdy   = m_pready_i[i];
                w_port_err   = m_pslverr_i[i];
                w_port_rdata = m_prdata_i[i*DataWidth +: DataWidth];
            end
        end
    end

    // Upstream response: decode miss, then port completion, then watchdog expiry.
    always_comb begin
        s_pready_o  = 1'b0;
        s_pslverr_o = 1'b0;
        s_prdata_o  = '0;
        w_err       = 1'b0;
        w_cause     = 2'b00;
        if (r_state == ST_ACCESS) begin
            if (r_miss) begin
                s_pready_o  = 1'b1;
                s_pslverr_o = 1'b1;
                w_err       = 1'b1;
                w_cause     = CauseDecode;
            end else if (w_port_rdy) begin
                s_pready_o  = 1'b1;
                s_pslverr_o = w_port_err;
                s_prdata_o  = w_port_rdata;
            end else if ((TimeoutCycles != 0) && (r_cnt == CntMax)) begin
                s_pready_o  = 1'b1;
                s_pslverr_o = 1'b1;
                w_err       = 1'b1;
                w_cause     = CauseTimeout;
            end
        end
    end

    // Transfer tracking FSM: latches the decode at setup and counts stalled access cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_miss  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (s_psel_i) begin
                        r_state <= ST_ACCESS;
                        r_sel   <= w_dec_sel;
                        r_miss  <= w_dec_miss;
                        r_cnt   <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (s_pready_o) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt != CntMax) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky error capture; a new error takes precedence over a same-cycle clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_irq   <= 1'b0;
            r_err_cause <= 2'b00;
            r_err_addr  <= '0;
        end else begin
            r_err_irq <= w_err;
            if (w_err) begin
                r_err_cause <= w_cause;
                r_err_addr  <= s_paddr_i;
            end else if (err_clr_i) begin
                r_err_cause <= 2'b00;
                r_err_addr  <= '0;
            end
        end
    end

    assign err_irq_o   = r_err_irq;
    assign err_cause_o = r_err_cause;
    assign err_addr_o  = r_err_addr;

endmodule

// File: tb/tb_apb_err_demux.sv
// Testbench for apb_err_demux: directed scenarios followed by randomized
// transfers predicted by a transaction-level model of the address map,
// wait-state and watchdog behaviour.
module tb_apb_err_demux;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         s_psel = 1'b0, s_penable = 1'b0, s_pwrite = 1'b0;
    logic [31:0]  s_paddr = '0, s_pwdata = '0;
    logic [31:0]  s_prdata;
    logic         s_pready, s_pslverr;
    logic [3:0]   m_psel;
    logic         m_penable, m_pwrite;
    logic [31:0]  m_paddr, m_pwdata;
    logic [127:0] m_prdata = '0;
    logic [3:0]   m_pready = '0, m_pslverr = '0;
    logic         err_irq;
    logic [1:0]   err_cause;
    logic [31:0]  err_addr;
    logic         err_clr = 1'b0;

    int n_pass  = 0;
    int n_total = 0;

    // Model state for the error capture registers.
    logic [1:0]  exp_cause = 2'b00;
    logic [31:0] exp_addr  = '0;
    logic        exp_irq   = 1'b0;

    apb_err_demux dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .s_psel_i    (s_psel),
        .s_penable_i (s_penable),
        .s_pwrite_i  (s_pwrite),
        .s_paddr_i   (s_paddr),
        .s_pwdata_i  (s_pwdata),
        .s_prdata_o  (s_prdata),
        .s_pready_o  (s_pready),
        .s_pslverr_o (s_pslverr),
        .m_psel_o    (m_psel),
        .m_penable_o (m_penable),
        .m_pwrite_o  (m_pwrite),
        .m_paddr_o   (m_paddr),
        .m_pwdata_o  (m_pwdata),
        .m_prdata_i  (m_prdata),
        .m_pready_i  (m_pready),
        .m_pslverr_i (m_pslverr),
        .err_irq_o   (err_irq),
        .err_cause_o (err_cause),
        .err_addr_o  (err_addr),
        .err_clr_i   (err_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Address map: four 256-byte windows starting at 0x0003_0000.
    function automatic int model_port(input logic [31:0] a);
        if (a >= 32'h0003_0000 && a < 32'h0003_0400) return int'((a - 32'h0003_0000) >> 8);
        return -1;
    endfunction

    function automatic logic [3:0] onehot(input int p);
        if (p < 0) return 4'b0000;
        return 4'(1 << p);
    endfunction

    // Target port asserts pready in access cycle wait_n+1; other ports drive noise.
    task automatic drive_ports(input int tgt, input int k, input int wait_n,
                               input logic [31:0] rd, input logic perr);
        for (int p = 0; p < 4; p++) begin
            if (p == tgt) begin
                m_pready[p]         = (k == wait_n + 1);
                m_pslverr[p]        = perr;
                m_prdata[p*32 +: 32] = rd;
            end else begin
                m_pready[p]         = 1'($urandom);
                m_pslverr[p]        = 1'($urandom);
                m_prdata[p*32 +: 32] = $urandom;
            end
        end
    endtask

    // One full transfer, entered and left just after a rising edge.
    task automatic xfer(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                        input int wait_n, input logic [31:0] rd, input logic perr);
        int          tgt;
        int          ex_done, got_done;
        logic        ex_err, got_err;
        logic [31:0] ex_rd, got_rd;
        tgt = model_port(a);
        if (tgt < 0) begin
            ex_done = 1; ex_err = 1'b1; ex_rd = '0;
        end else if (wait_n <= TO) begin
            ex_done = wait_n + 1; ex_err = perr; ex_rd = rd;
        end else begin
            ex_done = TO + 1; ex_err = 1'b1; ex_rd = '0;
        end
        got_done = -1; got_err = 1'b0; got_rd = '0;
        s_psel = 1'b1; s_penable = 1'b0; s_paddr = a; s_pwrite = wr; s_pwdata = wd;
        drive_ports(tgt, 0, wait_n, rd, perr);
        @(negedge clk);
        chk("psel_setup", m_psel, onehot(tgt));
        chk("rdy_setup", s_pready, 1'b0);
        chk("fwd_addr", m_paddr, a);
        chk("fwd_wr_data", {m_pwrite, m_pwdata}, {wr, wd});
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            s_penable = 1'b1;
            drive_ports(tgt, k, wait_n, rd, perr);
            @(negedge clk);
            if (k == 1) chk("psel_access", m_psel, onehot(tgt));
            if (s_pready) begin
                got_done = k; got_err = s_pslverr; got_rd = s_prdata;
                break;
            end
        end
        chk("done_cycle", got_done, ex_done);
        chk("pslverr", got_err, ex_err);
        chk("prdata", got_rd, ex_rd);
        exp_irq = (tgt < 0) || (wait_n > TO);
        if (exp_irq) begin
            exp_cause = (tgt < 0) ? 2'b01 : 2'b10;
            exp_addr  = a;
        end
        @(posedge clk); #1;
    endtask

    // Go idle and check the error capture registers and the irq pulse width.
    task automatic idle_chk();
        s_psel = 1'b0; s_penable = 1'b0; m_pready = '0;
        @(negedge clk);
        chk("err_irq", err_irq, exp_irq);
        chk("err_cause", err_cause, exp_cause);
        chk("err_addr", err_addr, exp_addr);
        @(posedge clk); #1;
        @(negedge clk);
        chk("irq_pulse_end", err_irq, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] a;
        int          w;
        // Reset state
        @(negedge clk);
        chk("rst_pready", s_pready, 1'b0);
        chk("rst_pslverr", s_pslverr, 1'b0);
        chk("rst_prdata", s_prdata, 32'h0);
        chk("rst_psel", m_psel, 4'h0);
        chk("rst_irq", err_irq, 1'b0);
        chk("rst_cause", err_cause, 2'b00);
        chk("rst_addr", err_addr, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-wait write to port 1
        xfer(32'h0003_0104, 1'b1, 32'hA5, 0, 32'h1111_2222, 1'b0);
        idle_chk();
        // Read with three wait states from port 2
        xfer(32'h0003_0208, 1'b0, 32'h0, 3, 32'hDEAD_BEEF, 1'b0);
        idle_chk();
        // Unmapped read -> decode error
        xfer(32'h1000_0000, 1'b0, 32'h0, 0, 32'h0, 1'b0);
        idle_chk();
        // Port 3 never ready -> timeout
        xfer(32'h0003_0300, 1'b0, 32'h0, 1000, 32'h0, 1'b0);
        idle_chk();
        // Port 3 ready exactly in the timeout cycle -> normal completion
        xfer(32'h0003_0310, 1'b0, 32'h0, TO, 32'h1234_5678, 1'b0);
        idle_chk();

        // Reset during a stalled access
        s_psel = 1'b1; s_penable = 1'b0; s_paddr = 32'h0003_0320;
        drive_ports(3, 0, 1000, 32'h0, 1'b0);
        @(posedge clk); #1;
        s_penable = 1'b1;
        drive_ports(3, 1, 1000, 32'h0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_pready", s_pready, 1'b0);
        chk("mid_rst_pslverr", s_pslverr, 1'b0);
        chk("mid_rst_psel", m_psel, 4'h0);
        chk("mid_rst_err", {err_irq, err_cause, err_addr}, 35'h0);
        exp_cause = 2'b00; exp_addr = '0; exp_irq = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; s_psel = 1'b0; s_penable = 1'b0; m_pready = '0;
        @(posedge clk); #1;
        xfer(32'h0003_0010, 1'b0, 32'h0, 2, 32'hCAFE_F00D, 1'b0);
        idle_chk();

        // Decode error coincident with clear: error wins
        err_clr = 1'b1;
        xfer(32'h0003_0400, 1'b0, 32'h0, 0, 32'h0, 1'b0);
        err_clr = 1'b0;
        idle_chk();
        // Clear alone
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        exp_cause = 2'b00; exp_addr = '0;
        @(negedge clk);
        chk("clr_cause", err_cause, 2'b00);
        chk("clr_addr", err_addr, 32'h0);
        @(posedge clk); #1;

        // Back-to-back transfers, no idle cycle between them
        xfer(32'h0003_0004, 1'b1, 32'h55, 0, 32'h0, 1'b0);
        xfer(32'h0003_01FC, 1'b0, 32'h0, 1, 32'h0BAD_F00D, 1'b1);
        idle_chk();

        // Randomized transfers
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2: a = 32'h0003_0000 + $urandom_range(0, 32'h3FF);
                3:       a = $urandom;
                4: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'h0002_FFFF;
                        1: a = 32'h0003_0400;
                        2: a = 32'h0003_00FF;
                        default: a = 32'h0003_0100;
                    endcase
                end
                default: a = 32'h0003_0000 + $urandom_range(32'h3F0, 32'h40F);
            endcase
            w = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 1, TO + 2) : $urandom_range(0, 6);
            xfer(a, 1'($urandom), $urandom, w, $urandom, 1'($urandom));
            if ($urandom_range(0, 2) != 0) idle_chk();
        end
        idle_chk();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
